// File: rtl/t07_mem_handler_if.sv
// t07 data-bus interface: word-addressed strobe/ack bus between
// the memory handler (master) and the data memory (slave).
interface t07_mem_handler_if #(
  parameter int ADDR_W = 32
);
  logic [ADDR_W-1:0] bus_addr;
  logic [31:0]       bus_wdata;
  logic [3:0]        bus_sel;
  logic              bus_ren;
  logic              bus_wen;
  logic              bus_ack;
  logic [31:0]       bus_rdata;

  modport master (
    output bus_addr,
    output bus_wdata,
    output bus_sel,
    output bus_ren,
    output bus_wen,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_addr,
    input  bus_wdata,
    input  bus_sel,
    input  bus_ren,
    input  bus_wen,
    output bus_ack,
    output bus_rdata
  );
endinterface

// File: rtl/t07_mem_handler.sv
// t07 data-memory handler: single-outstanding, stall-based load/store.
// Define T07_MISALIGN_TRAP_EN to trap misaligned half/word accesses.
module t07_mem_handler #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              memRead,
  input  logic              memWrite,
  input  logic [3:0]        memOp,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata,
  output logic              done,
  output logic              stall,
  output logic              bus_err,
  t07_mem_handler_if.master bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(TIMEOUT);
  localparam logic [CW-1:0] CNT_TOP = CW'(TIMEOUT - 1);

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ren_q, ren_d;
  logic              wen_q, wen_d;
  logic [ADDR_W-1:0] baddr_q, baddr_d;
  logic [3:0]        sel_q, sel_d;
  logic [31:0]       bwd_q, bwd_d;
  logic              ld_q, ld_d;
  logic              sgn_q, sgn_d;
  logic [1:0]        sz_q, sz_d;
  logic [1:0]        off_q, off_d;
  logic              err_q, err_d;
  logic [31:0]       rdata_q, rdata_d;

  logic        is_ld, is_st, sgn, valid, trap;
  logic [1:0]  sz;
  logic [3:0]  sel;
  logic [31:0] wrep;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_val;

  always_comb begin
    is_ld = 1'b0;
    is_st = 1'b0;
    sgn   = 1'b0;
    sz    = SZ_W;
    unique case (1'b1)
      (memOp == 4'd1): begin is_ld = 1'b1; sgn = 1'b1; sz = SZ_B; end
      (memOp == 4'd2): begin is_ld = 1'b1; sgn = 1'b1; sz = SZ_H; end
      (memOp == 4'd3): begin is_ld = 1'b1; sz = SZ_W; end
      (memOp == 4'd4): begin is_ld = 1'b1; sz = SZ_B; end
      (memOp == 4'd5): begin is_ld = 1'b1; sz = SZ_H; end
      (memOp == 4'd6): begin is_st = 1'b1; sz = SZ_B; end
      (memOp == 4'd7): begin is_st = 1'b1; sz = SZ_H; end
      (memOp == 4'd8): begin is_st = 1'b1; sz = SZ_W; end
      default: ;
    endcase
  end

  assign valid = (memRead & ~memWrite & is_ld)
               | (memWrite & ~memRead & is_st);

  always_comb begin
    sel  = 4'b1111;
    wrep = wdata;
    unique case (sz)
      SZ_B: begin
        sel  = 4'b0001 << addr[1:0];
        wrep = {4{wdata[7:0]}};
      end
      SZ_H: begin
        sel  = addr[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

`ifdef T07_MISALIGN_TRAP_EN
  assign trap = valid
              & (((sz == SZ_H) & addr[0])
              |  ((sz == SZ_W) & (addr[1:0] != 2'b00)));
`else
  assign trap = 1'b0;
`endif

  // extraction uses the offset captured at request time
  assign lane_b = bus.bus_rdata[{off_q, 3'b000} +: 8];
  assign lane_h = off_q[1] ? bus.bus_rdata[31:16]
                           : bus.bus_rdata[15:0];

  always_comb begin
    ld_val = bus.bus_rdata;
    unique case (sz_q)
      SZ_B: ld_val = sgn_q ? {{24{lane_b[7]}}, lane_b}
                           : {24'b0, lane_b};
      SZ_H: ld_val = sgn_q ? {{16{lane_h[15]}}, lane_h}
                           : {16'b0, lane_h};
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ren_d   = ren_q;
    wen_d   = wen_q;
    baddr_d = baddr_q;
    sel_d   = sel_q;
    bwd_d   = bwd_q;
    ld_d    = ld_q;
    sgn_d   = sgn_q;
    sz_d    = sz_q;
    off_d   = off_q;
    err_d   = err_q;
    rdata_d = rdata_q;
    unique case (state_q)
      IDLE: begin
        if (valid) begin
          baddr_d = {addr[ADDR_W-1:2], 2'b00};
          sel_d   = sel;
          bwd_d   = wrep;
          ld_d    = is_ld;
          sgn_d   = sgn;
          sz_d    = sz;
          off_d   = addr[1:0];
          cnt_d   = '0;
          err_d   = trap;
          if (trap) begin
            state_d = DONE;
          end else begin
            state_d = BUSY;
            ren_d   = is_ld;
            wen_d   = ~is_ld;
          end
        end
      end
      BUSY: begin
        if (bus.bus_ack) begin
          if (ld_q) rdata_d = ld_val;
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          state_d = DONE;
        end else if (cnt_q == CNT_TOP) begin
          ren_d   = 1'b0;
          wen_d   = 1'b0;
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        err_d   = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ren_q   <= 1'b0;
      wen_q   <= 1'b0;
      baddr_q <= '0;
      sel_q   <= '0;
      bwd_q   <= '0;
      ld_q    <= 1'b0;
      sgn_q   <= 1'b0;
      sz_q    <= SZ_B;
      off_q   <= '0;
      err_q   <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ren_q   <= ren_d;
      wen_q   <= wen_d;
      baddr_q <= baddr_d;
      sel_q   <= sel_d;
      bwd_q   <= bwd_d;
      ld_q    <= ld_d;
      sgn_q   <= sgn_d;
      sz_q    <= sz_d;
      off_q   <= off_d;
      err_q   <= err_d;
      rdata_q <= rdata_d;
    end
  end

  // stall must fall with reset even while a request is still presented
  assign stall = ~rst & (((state_q == IDLE) & valid)
                       | (state_q == BUSY));
  assign done    = (state_q == DONE);
  assign bus_err = done & err_q;
  assign rdata   = rdata_q;

  assign bus.bus_addr  = baddr_q;
  assign bus.bus_wdata = bwd_q;
  assign bus.bus_sel   = sel_q;
  assign bus.bus_ren   = ren_q;
  assign bus.bus_wen   = wen_q;

endmodule
